// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo_2048 read-side controller.
//   DefDataWidth / DefDepth : default word width and attached FIFO depth
//   cnt_width()             : width of burst-length and word counters
//   state_t                 : burst controller FSM encoding
package fifo_pkg;

  localparam int DefDataWidth = 16;
  localparam int DefDepth     = 2048;

  // One extra bit so a full-depth count (Depth itself) is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_burst_reader_skid_buf2.sv
// skid_buf2: 2-entry register FIFO that absorbs the FIFO read latency.
//   clk, rst : clock, synchronous active-high reset (clears contents)
//   wr_en    : push wr_data (ignored when full unless popping same cycle)
//   rd_en    : pop the head entry (ignored when empty)
//   rd_data  : head entry (entry 0)
//   occ      : number of valid entries, 0..2
module skid_buf2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic [1:0]   occ
);

  logic [W-1:0] ent0;
  logic [W-1:0] ent1;
  logic [1:0]   occ_q;
  logic         do_rd;
  logic         do_wr;

  assign do_rd   = rd_en & (occ_q != 2'd0);
  assign do_wr   = wr_en & ((occ_q != 2'd2) | do_rd);
  assign rd_data = ent0;
  assign occ     = occ_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0  <= '0;
      ent1  <= '0;
      occ_q <= 2'd0;
    end else begin
      case ({do_wr, do_rd})
        2'b10: begin
          if (occ_q == 2'd0) ent0 <= wr_data;
          else               ent1 <= wr_data;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          // Pop and push together: the new word lands right behind the
          // surviving entry, so occupancy is unchanged.
          if (occ_q == 2'd1) begin
            ent0 <= wr_data;
          end else begin
            ent0 <= ent1;
            ent1 <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains burst_len words from fifo_2048 onto a
// valid/ready stream.
//   start/burst_len      : command pulse, accepted only in IDLE
//   busy/done            : busy from accepted start through the done pulse
//   fifo_empty/fifo_rd/fifo_data : FIFO read port, data valid 1 cycle after rd
//   m_valid/m_ready/m_data/m_last : output stream
//   sent_cnt             : words accepted downstream in current/last burst
//   state_dbg            : current FSM state
// Handshake: a word transfers on any rising edge where m_valid & m_ready;
// once m_valid is high, m_valid/m_data/m_last hold until that transfer.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int DataWidth = DefDataWidth,
  parameter int Depth     = DefDepth,
  parameter int CntWidth  = cnt_width(Depth)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CntWidth-1:0]  burst_len,
  output logic                 busy,
  output logic                 done,
  input  logic                 fifo_empty,
  output logic                 fifo_rd,
  input  logic [DataWidth-1:0] fifo_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DataWidth-1:0] m_data,
  output logic                 m_last,
  output logic [CntWidth-1:0]  sent_cnt,
  output logic [1:0]           state_dbg
);

  state_t              state;
  state_t              state_nxt;
  logic [CntWidth-1:0] rd_left;
  logic [CntWidth-1:0] out_left;
  logic                inflight;
  logic [1:0]          occ;
  logic                pop;
  logic [2:0]          level;

  assign pop = m_valid & m_ready;

  // Occupancy the buffer will have once the in-flight word lands and this
  // cycle's pop leaves; a new read is allowed only if a slot stays free.
  // pop implies occ>=1, so the subtraction cannot wrap.
  assign level = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

  assign fifo_rd = ~rst & (state == RUN) & ~fifo_empty &
                   (rd_left != '0) & (level < 3'd2);

  skid_buf2 #(.W(DataWidth)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inflight),
    .wr_data (fifo_data),
    .rd_en   (pop),
    .rd_data (m_data),
    .occ     (occ)
  );

  assign m_valid   = (occ != 2'd0);
  assign m_last    = m_valid & (out_left == CntWidth'(1));
  assign busy      = (state == RUN) | (state == DONE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (burst_len == '0) ? DONE : RUN;
      RUN:  if (pop && (out_left == CntWidth'(1))) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rd_left  <= '0;
      out_left <= '0;
      sent_cnt <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_rd;
      if ((state == IDLE) && start) begin
        rd_left  <= burst_len;
        out_left <= burst_len;
        sent_cnt <= '0;
      end else begin
        if (fifo_rd) rd_left <= rd_left - CntWidth'(1);
        if (pop) begin
          out_left <= out_left - CntWidth'(1);
          sent_cnt <= sent_cnt + CntWidth'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

  localparam int DW = 16;
  localparam int CW = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [CW-1:0] burst_len = '0;
  logic          busy, done, fifo_rd, m_valid, m_last;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [CW-1:0] sent_cnt;
  logic [1:0]    state_dbg;

  fifo_burst_reader dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
    .busy(busy), .done(done), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .fifo_data(fifo_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .sent_cnt(sent_cnt),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];      // words the burst must deliver, in order
  logic [DW-1:0] fifo_q[$];     // FIFO contents model
  logic [DW-1:0] stream_q[$];   // FIFO words not yet assigned to a burst
  logic [DW-1:0] wr_req_q[$];   // pending FIFO writes
  int total = 0;
  int bad = 0;
  int need = 0;
  int cur_len = 0;
  int hs_cnt = 0;
  int rd_cnt = 0;
  int done_seen = 0;
  int mode = 0;
  int ph = 0;
  bit rd_seen = 0;
  bit zero_pend = 0;
  bit exp_done = 0;
  bit after_done = 0;
  bit prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- FIFO + reference model ----------------
  always @(posedge clk) begin
    if (rd_seen) begin
      if (fifo_q.size() == 0) begin
        total++; bad++;
        $display("FAIL fifo_underflow read with empty model FIFO at %0t", $time);
      end else begin
        fifo_data <= fifo_q.pop_front();
      end
    end
    while (wr_req_q.size() > 0) begin
      logic [DW-1:0] w;
      w = wr_req_q.pop_front();
      fifo_q.push_back(w);
      stream_q.push_back(w);
    end
    fifo_empty <= (fifo_q.size() == 0);
    while (need > 0 && stream_q.size() > 0) begin
      exp_q.push_back(stream_q.pop_front());
      need--;
    end
  end

  // ---------------- m_ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (mode)
      0: m_ready = 1'b1;
      1: begin m_ready = (ph == 0) || (ph == 3); ph = (ph + 1) % 4; end
      default: m_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    rd_seen = fifo_rd;
    if (rst) begin
      prev_stall = 0;
      exp_done = 0;
      after_done = 0;
    end else begin
      bit nxt;
      nxt = 0;
      chk("done_timing", done, exp_done);
      if (m_valid) begin
        if (prev_stall) begin
          chk("hold_data", m_data, prev_data);
          chk("hold_last", m_last, prev_last);
        end
        chk("m_last", m_last, (hs_cnt == cur_len - 1));
        if (m_ready) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_word actual=%0h required=none", m_data);
          end else begin
            chk("m_data", m_data, exp_q.pop_front());
          end
          hs_cnt++;
          if (hs_cnt == cur_len) nxt = 1;
        end
      end else if (prev_stall) begin
        chk("hold_valid", m_valid, 1'b1);
      end
      prev_stall = m_valid & ~m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (fifo_rd) begin
        chk("rd_when_empty", fifo_empty, 1'b0);
        rd_cnt++;
      end
      if (after_done) chk("busy_after_done", busy, 1'b0);
      if (done) begin
        chk("sent_cnt", sent_cnt, cur_len);
        chk("rd_count", rd_cnt, cur_len);
        chk("busy_at_done", busy, 1'b1);
        chk("exp_left", exp_q.size(), 0);
        done_seen++;
      end
      after_done = done;
      if (zero_pend) begin nxt = 1; zero_pend = 0; end
      exp_done = nxt;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_words(input int n, input bit seq, input int base);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++)
      wr_req_q.push_back(seq ? DW'(base + i) : DW'($urandom_range(0, 65535)));
  endtask

  task automatic issue_start(input int len, input bit accept);
    @(posedge clk); #1;
    start = 1'b1;
    burst_len = CW'(len);
    if (accept) begin
      cur_len = len; hs_cnt = 0; rd_cnt = 0; need = len;
      if (len == 0) zero_pend = 1;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int d0;
    bit got;
    d0 = done_seen;
    got = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      if (done_seen != d0) begin got = 1; break; end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL done_timeout actual=no_done required=done within %0d cycles", max_cyc);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    chk("rst_sent", sent_cnt, 0);
    chk("rst_rd", fifo_rd, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    need = 0;
    stream_q = fifo_q;
    zero_pend = 0;
    cur_len = 0; hs_cnt = 0; rd_cnt = 0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    do_reset();

    // straight burst of 10 at full rate
    mode = 0;
    write_words(10, 1, 0);
    repeat (2) @(posedge clk);
    issue_start(10, 1);
    wait_done(100);

    // 1,0,0,1 backpressure
    write_words(10, 1, 0);
    repeat (2) @(posedge clk);
    mode = 1; ph = 0;
    issue_start(10, 1);
    wait_done(200);

    // FIFO runs dry mid-burst, refilled later
    mode = 0;
    write_words(3, 0, 0);
    repeat (2) @(posedge clk);
    issue_start(6, 1);
    repeat (20) @(posedge clk);
    chk("busy_while_starved", busy, 1);
    write_words(3, 0, 0);
    wait_done(100);

    // zero-length burst
    issue_start(0, 1);
    wait_done(10);

    // reset mid-burst, then a short burst
    write_words(10, 1, 100);
    repeat (2) @(posedge clk);
    issue_start(10, 1);
    for (int i = 0; i < 50 && hs_cnt < 4; i++) @(posedge clk);
    do_reset();
    issue_start(2, 1);
    wait_done(50);

    // second start during RUN ignored
    write_words(12, 0, 0);
    repeat (2) @(posedge clk);
    mode = 2;
    issue_start(8, 1);
    repeat (2) @(posedge clk);
    issue_start(5, 0);
    wait_done(200);

    // random bursts under random backpressure
    for (int k = 0; k < 4; k++) begin
      int len;
      len = $urandom_range(1, 20);
      write_words(len, 0, 0);
      repeat (2) @(posedge clk);
      issue_start(len, 1);
      wait_done(400);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
